// File: rtl/bb_logic_pipe_if.sv
// Purpose : handshake bundle between a streaming producer/consumer and bb_logic_pipe.
// Latency : n/a (wires only).
// Backpressure: io_in_ready / io_out_ready carry the valid-ready handshakes on both sides.
//
// Ports (signals)
//   io_in_valid/io_in_ready     input beat handshake
//   io_in_a, io_in_b            WIDTH-bit operands
//   io_in_op                    00 AND, 01 OR, 10 XOR, 11 ACC (burst AND-reduce)
//   io_in_last                  final beat of an ACC burst
//   io_out_valid/io_out_ready   result beat handshake
//   io_out_result               WIDTH-bit result
//   io_out_beats                CNT_W-bit count of beats folded into the result
// master : the environment (drives operands, consumes results)
// slave  : the logic unit itself
interface bb_logic_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a;
  logic [WIDTH-1:0] io_in_b;
  logic [1:0]       io_in_op;
  logic             io_in_last;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_result;
  logic [CNT_W-1:0] io_out_beats;

  modport master (
    output io_in_valid, io_in_a, io_in_b, io_in_op, io_in_last, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_result, io_out_beats
  );

  modport slave (
    input  io_in_valid, io_in_a, io_in_b, io_in_op, io_in_last, io_out_ready,
    output io_in_ready, io_out_valid, io_out_result, io_out_beats
  );
endinterface

// File: rtl/bb_logic_pipe.sv
// Purpose : WIDTH-bit bitwise AND/OR/XOR unit with burst AND-accumulate, STAGES-deep pipeline.
// Latency : STAGES cycles from accept to io_out_* when unstalled; each stall cycle adds one.
// Backpressure: whole pipe freezes when the output holds an unaccepted beat; io_in_ready follows.
//
// Ports
//   clock  rising-edge clock for all state
//   reset  synchronous, active-high; flushes the pipe and discards any partial burst
//   io     bb_logic_pipe_if.slave: input beat (a, b, op, last) and output beat (result, beats)
module bb_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 4
) (
  input  logic            clock,
  input  logic            reset,
  bb_logic_pipe_if.slave  io
);

  localparam logic [1:0]       OP_AND = 2'b00;
  localparam logic [1:0]       OP_OR  = 2'b01;
  localparam logic [1:0]       OP_XOR = 2'b10;
  localparam logic [1:0]       OP_ACC = 2'b11;
  localparam logic [WIDTH-1:0] ONES   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             vld;
    logic [CNT_W-1:0] beats;
    logic [WIDTH-1:0] dat;
  } stage_t;

  typedef enum logic {
    ACC_IDLE,
    ACC_ACCUM
  } acc_state_t;

  stage_t           pipe_q [STAGES];
  stage_t           push_d;
  acc_state_t       state_q;
  acc_state_t       state_d;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_v;
  logic [CNT_W-1:0] acc_n;
  logic             adv;
  logic             accept;
  logic             acc_beat;

  // The pipe moves as one unit: it may advance whenever the last stage is
  // empty or being drained this cycle. No skid buffer, so the input sees the
  // same condition combinationally.
  assign adv         = io.io_out_ready | ~pipe_q[STAGES-1].vld;
  assign accept      = io.io_in_valid & adv;
  assign acc_beat    = accept & (io.io_in_op == OP_ACC);
  assign io.io_in_ready = adv;

  assign io.io_out_valid  = pipe_q[STAGES-1].vld;
  assign io.io_out_result = pipe_q[STAGES-1].dat;
  assign io.io_out_beats  = pipe_q[STAGES-1].beats;

  // ACC FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ACC FSM: next state. Only accepted ACC beats move it; other ops that
  // arrive mid-burst leave the burst untouched.
  always_comb begin
    state_d = state_q;
    if (acc_beat) begin
      state_d = io.io_in_last ? ACC_IDLE : ACC_ACCUM;
    end
  end

  // ACC FSM: outputs. A burst starts from an all-ones seed so the first beat
  // reduces to a&b, and the beat count saturates rather than wrapping.
  always_comb begin
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] base;
    seed  = (state_q == ACC_IDLE) ? ONES : acc_q;
    base  = (state_q == ACC_IDLE) ? '0 : cnt_q;
    acc_v = seed & io.io_in_a & io.io_in_b;
    acc_n = (base == CNT_MAX) ? CNT_MAX : base + CNT_W'(1);

    push_d = '0;
    if (accept) begin
      unique case (io.io_in_op)
        OP_AND: push_d = '{vld: 1'b1, beats: CNT_W'(1), dat: io.io_in_a & io.io_in_b};
        OP_OR:  push_d = '{vld: 1'b1, beats: CNT_W'(1), dat: io.io_in_a | io.io_in_b};
        OP_XOR: push_d = '{vld: 1'b1, beats: CNT_W'(1), dat: io.io_in_a ^ io.io_in_b};
        OP_ACC: begin
          // Non-final burst beats enter the pipe as bubbles.
          if (io.io_in_last) begin
            push_d = '{vld: 1'b1, beats: acc_n, dat: acc_v};
          end
        end
        default: push_d = '0;
      endcase
    end
  end

  // Running accumulator and beat count for the open burst.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= ONES;
      cnt_q <= '0;
    end else if (acc_beat) begin
      if (io.io_in_last) begin
        acc_q <= ONES;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_v;
        cnt_q <= acc_n;
      end
    end
  end

  // Pipeline registers; a stalled pipe holds every stage, which keeps io_out_*
  // stable while the consumer is not ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (adv) begin
      pipe_q[0] <= push_d;
      for (int i = 1; i < STAGES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_bb_logic_pipe.sv
// Bench for bb_logic_pipe: two instances (CNT_W=4 and CNT_W=2) driven by the
// same stimulus, checked against a beat-level reference model.
module tb_bb_logic_pipe;

  localparam int STAGES = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;

  always #5 clock = ~clock;

  bb_logic_pipe_if #(.WIDTH(8), .CNT_W(4)) if_a ();
  bb_logic_pipe_if #(.WIDTH(8), .CNT_W(2)) if_b ();

  assign if_a.io_in_valid  = in_valid;
  assign if_a.io_in_a      = in_a;
  assign if_a.io_in_b      = in_b;
  assign if_a.io_in_op     = in_op;
  assign if_a.io_in_last   = in_last;
  assign if_a.io_out_ready = out_ready;
  assign if_b.io_in_valid  = in_valid;
  assign if_b.io_in_a      = in_a;
  assign if_b.io_in_b      = in_b;
  assign if_b.io_in_op     = in_op;
  assign if_b.io_in_last   = in_last;
  assign if_b.io_out_ready = out_ready;

  bb_logic_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .io(if_a)
  );
  bb_logic_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .io(if_b)
  );

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] beats;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];
  beat_t pops_a[$];
  beat_t pops_b[$];
  int    out_cyc[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    acc_cyc_last = 0;
  logic  acc_now = 1'b0;
  logic  ir_seen = 1'b0;
  logic  prev_hold = 1'b0;
  beat_t prev_a;
  beat_t prev_b;

  // Reference model: burst state as plain integers, saturation applied at output.
  logic [7:0] m_acc = 8'hFF;
  int         m_cnt = 0;
  bit         m_burst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic void model_accept(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op, input logic last);
    logic [7:0] v;
    case (op)
      2'd0: begin q_a.push_back('{a & b, 4'd1}); q_b.push_back('{a & b, 4'd1}); end
      2'd1: begin q_a.push_back('{a | b, 4'd1}); q_b.push_back('{a | b, 4'd1}); end
      2'd2: begin q_a.push_back('{a ^ b, 4'd1}); q_b.push_back('{a ^ b, 4'd1}); end
      default: begin
        v     = (m_burst ? m_acc : 8'hFF) & a & b;
        m_cnt = (m_burst ? m_cnt : 0) + 1;
        if (last) begin
          q_a.push_back('{v, 4'(sat(m_cnt, 15))});
          q_b.push_back('{v, 4'(sat(m_cnt, 3))});
          m_burst = 1'b0;
        end else begin
          m_burst = 1'b1;
          m_acc   = v;
        end
      end
    endcase
  endfunction

  // One clock cycle: sample at negedge, check, update model, then advance.
  task automatic step();
    logic  ov_a, ov_b, exp_ir;
    beat_t got_a, got_b, e;
    @(negedge clock);
    ov_a    = if_a.io_out_valid;
    ov_b    = if_b.io_out_valid;
    got_a   = '{if_a.io_out_result, if_a.io_out_beats};
    got_b   = '{if_b.io_out_result, {2'b00, if_b.io_out_beats}};
    ir_seen = if_a.io_in_ready;
    acc_now = 1'b0;
    if (!reset) begin
      exp_ir = out_ready | ~ov_a;
      chk("valid_a_vs_b", ov_b, ov_a);
      chk("in_ready_a", if_a.io_in_ready, exp_ir);
      chk("in_ready_b", if_b.io_in_ready, exp_ir);
      if (prev_hold) begin
        chk("hold_valid", ov_a, 1);
        chk("hold_a", got_a, prev_a);
        chk("hold_b", got_b, prev_b);
      end
      if (ov_a && out_ready) begin
        if (q_a.size() == 0) begin
          chk("unexpected_out_a", ov_a, 0);
        end else begin
          e = q_a.pop_front();
          chk("result_a", got_a.res, e.res);
          chk("beats_a", got_a.beats, e.beats);
          pops_a.push_back(got_a);
          out_cyc.push_back(cyc);
        end
      end
      if (ov_b && out_ready) begin
        if (q_b.size() == 0) begin
          chk("unexpected_out_b", ov_b, 0);
        end else begin
          e = q_b.pop_front();
          chk("result_b", got_b.res, e.res);
          chk("beats_b", got_b.beats, e.beats);
          pops_b.push_back(got_b);
        end
      end
      if (in_valid && if_a.io_in_ready) begin
        acc_now      = 1'b1;
        acc_cyc_last = cyc;
        model_accept(in_a, in_b, in_op, in_last);
      end
      prev_hold = ov_a & ~out_ready;
    end else begin
      prev_hold = 1'b0;
    end
    prev_a = got_a;
    prev_b = got_b;
    @(posedge clock);
    cyc++;
    if (reset) begin
      q_a.delete();
      q_b.delete();
      m_burst = 1'b0;
      m_cnt   = 0;
      m_acc   = 8'hFF;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic last);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_last = last;
    do begin
      step();
      budget++;
    end while (!acc_now && budget < 100);
    if (!acc_now) chk("send_timeout", acc_now, 1);
  endtask

  task automatic drain();
    int budget;
    budget    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q_a.size() != 0 || q_b.size() != 0) && budget < 100) begin
      step();
      budget++;
    end
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    repeat (STAGES + 1) step();
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("rst_valid_a", if_a.io_out_valid, 0);
    chk("rst_valid_b", if_b.io_out_valid, 0);
    chk("rst_result", if_a.io_out_result, 0);
    chk("rst_beats", if_a.io_out_beats, 0);
    chk("rst_in_ready", if_a.io_in_ready, 1);
  endtask

  task automatic clear_log();
    pops_a.delete();
    pops_b.delete();
    out_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] ta [6];
    logic [7:0] tb [6];
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_last = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset_dut();

    // AND/OR/XOR back-to-back: results on cycles 2,3,4 after first accept.
    clear_log();
    send(8'hF0, 8'h3C, 2'd0, 1'b0);
    c0 = acc_cyc_last;
    send(8'hF0, 8'h3C, 2'd1, 1'b0);
    send(8'hF0, 8'h3C, 2'd2, 1'b0);
    drain();
    chk("t1_count", pops_a.size(), 3);
    chk("t1_and", pops_a[0].res, 8'h30);
    chk("t1_or", pops_a[1].res, 8'hFC);
    chk("t1_xor", pops_a[2].res, 8'hCC);
    chk("t1_beats", pops_a[2].beats, 1);
    for (int i = 0; i < 3; i++) chk("t1_latency", out_cyc[i] - c0, 2 + i);

    // Three-beat ACC burst: one result STAGES cycles after the last beat.
    clear_log();
    send(8'hFF, 8'hFE, 2'd3, 1'b0);
    send(8'h7F, 8'hFF, 2'd3, 1'b0);
    send(8'hF3, 8'hFF, 2'd3, 1'b1);
    c0 = acc_cyc_last;
    drain();
    chk("t2_count", pops_a.size(), 1);
    chk("t2_result", pops_a[0].res, 8'h72);
    chk("t2_beats", pops_a[0].beats, 3);
    chk("t2_latency", out_cyc[0] - c0, STAGES);

    // Backpressure: 5 stalled cycles in the middle of 6 AND beats.
    clear_log();
    for (int i = 0; i < 6; i++) begin
      ta[i] = 8'(i * 37 + 5);
      tb[i] = 8'(8'hF7 - i * 16);
    end
    send(ta[0], tb[0], 2'd0, 1'b0);
    send(ta[1], tb[1], 2'd0, 1'b0);
    out_ready = 1'b0;
    in_a = ta[2]; in_b = tb[2];
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_stall_in_ready", ir_seen, 0);
    end
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) send(ta[i], tb[i], 2'd0, 1'b0);
    drain();
    chk("t3_count", pops_a.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_order", pops_a[i].res, ta[i] & tb[i]);

    // Five-beat burst: CNT_W=2 instance saturates at 3.
    clear_log();
    for (int i = 0; i < 5; i++) send(8'hFF, 8'hFF, 2'd3, i == 4);
    drain();
    chk("t4_result", pops_b[0].res, 8'hFF);
    chk("t4_beats_sat", pops_b[0].beats, 3);
    chk("t4_beats_wide", pops_a[0].beats, 5);

    // XOR beat in the middle of a burst passes through untouched.
    clear_log();
    send(8'hF0, 8'hFF, 2'd3, 1'b0);
    send(8'h0F, 8'hFF, 2'd2, 1'b0);
    send(8'h3C, 8'hFF, 2'd3, 1'b1);
    drain();
    chk("t5_xor", pops_a[0].res, 8'hF0);
    chk("t5_xor_beats", pops_a[0].beats, 1);
    chk("t5_acc", pops_a[1].res, 8'h30);
    chk("t5_acc_beats", pops_a[1].beats, 2);

    // Reset mid-burst drops the partial burst.
    clear_log();
    send(8'h12, 8'hFF, 2'd3, 1'b0);
    send(8'h34, 8'hFF, 2'd3, 1'b0);
    reset_dut();
    send(8'h55, 8'h55, 2'd3, 1'b1);
    drain();
    chk("t6_count", pops_a.size(), 1);
    chk("t6_result", pops_a[0].res, 8'h55);
    chk("t6_beats", pops_a[0].beats, 1);

    // Random traffic with random backpressure; producer holds a beat until taken.
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc_now) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom | ($urandom_range(0, 1) ? 32'hF0 : 32'h0F));
        in_op    = 2'($urandom_range(0, 3));
        in_last  = ($urandom_range(0, 2) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
